// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor d = a - b, LSB first, one bit per clock.
// Latency: start accepted at edge 0, result registered at edge WIDTH, done in the following cycle.
// Backpressure: start is ignored while busy; the next start can be accepted WIDTH+2 cycles after the previous one.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  // Full-subtractor bit cell on the current LSBs and the running borrow.
  logic ai, bi, diff, br_nxt, last_bit;

  assign ai       = a_sr[0];
  assign bi       = b_sr[0];
  assign diff     = ai ^ bi ^ br;
  assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE waits for start, RUN counts WIDTH bits, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, and result update only on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          r_sr <= {diff, r_sr[WIDTH-1:1]};
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            d  <= {diff, r_sr[WIDTH-1:1]};
            bo <= br_nxt;
          end
        end
        default: begin
          // DONE: results hold; nothing else changes.
        end
      endcase
    end
  end

endmodule
